inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Fetch sequencer for the instruction ROM: owns the PC, drives the ROM chip-enable and word address, and captures returned words into a registered IF/ID hand-off with valid/ready back-pressure.
- Sits between the ROM and the decode stage.
- Branch/jump redirect from later stages flushes the hand-off register and reloads the PC.
- A halt request parks fetch; out-of-range or misaligned PCs raise a sticky fault.

Parameters:
- ADDR_W, 10, ROM word-address width; ROM depth = 2**ADDR_W words.
- DATA_W, 32, ROM word / instruction width.
- PC_W, 32, byte-address PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_ce  out  1  ROM chip-enable; ROM data is valid combinationally in the same cycle.
- rom_addr  out  ADDR_W  ROM word index = pc[ADDR_W+1:2].
- rom_data  in  DATA_W  ROM read data; high-Z when rom_ce=0, never sampled then.
- id_valid  out  1  hand-off register holds an instruction.
- id_ready  in  1  decode accepts id_inst/id_pc this cycle.
- id_inst  out  DATA_W  fetched instruction.
- id_pc  out  PC_W  byte PC of id_inst.
- redir_valid  in  1  redirect request.
- redir_pc  in  PC_W  redirect target.
- halt_req  in  1  stop fetching.
- fault  out  1  sticky fetch fault.
- pc_out  out  PC_W  current PC register, for debug.

Behaviour:
- Reset: synchronous on rst=1 at the clock edge.
  - pc=RESET_PC, state=IDLE, id_valid=0, id_inst=0, id_pc=0, fault=0.
  - rom_ce=0 throughout reset and IDLE.
  - Reset mid-operation discards any held instruction.
- States: IDLE, FETCH, HALT, FAULT (2-bit encoding).
- IDLE -> FETCH unconditionally on the first edge after rst deasserts. First rom_ce=1 occurs in the second cycle after reset release.
- rom_ce (combinational) = (state==FETCH) && in_range && (!id_valid || id_ready).
  - in_range = (pc >> (ADDR_W+2)) == 0.
  - rom_addr is driven from pc in all states; it is a don't-care when rom_ce=0.
- FETCH with rom_ce=1, at the edge:
  - id_inst<=rom_data, id_pc<=pc, id_valid<=1, pc<=pc+4.
  - Latency: one cycle from PC presentation to id_valid.
  - Throughput: one instruction per cycle while id_ready=1.
- Back-pressure: id_valid=1 && id_ready=0 means id_inst, id_pc, id_valid and pc all hold, and rom_ce=0.
- Consumption: id_valid=1 && id_ready=1 with no new fetch (HALT/FAULT/out of range) clears id_valid to 0 at the edge.
- Out of range: in FETCH with !in_range, transition to FAULT and set fault<=1. The last legal word is fetched normally; the fault raises on the following cycle.
- Redirect (redir_valid=1), highest priority after rst:
  - At the edge: id_valid<=0 (flush, regardless of id_ready), pc<=redir_pc.
  - If redir_pc[1:0]!=0: state<=FAULT, fault<=1.
  - Otherwise state<=FETCH and fault<=0.
  - Redirect is the only exit from HALT and FAULT.
  - The redirect cycle itself does not fetch (rom_ce=0). Fetch from the target begins the next cycle, a 1-cycle bubble.
- halt_req=1 in FETCH without redirect: state<=HALT at the edge. A fetch enabled in that same cycle still completes. From the next cycle rom_ce=0, and the held instruction drains normally via id_ready.
- Simultaneous redirect and halt_req: redirect wins and halt_req is ignored that cycle. If halt_req persists, HALT is entered one cycle later.
- PC arithmetic: modulo 2**PC_W; the increment is always +4.
- fault: cleared only by rst or a valid aligned redirect.

Decomposition:
- Shared fetch package/header holds:
  - state encodings FS_IDLE=2'd0, FS_FETCH=2'd1, FS_HALT=2'd2, FS_FAULT=2'd3;
  - the PC increment constant 4;
  - the default RESET_PC;
  - ADDR_W/DATA_W defaults, shared with the ROM.
- One natural sub-module, if_id_reg: the valid/ready hand-off register with load/hold/flush controls. The PC and FSM stay in the top.

Test Plan:
- Reset release, id_ready=1, ROM word k = 32'h1000_0000+k:
  - cycle 1 IDLE with rom_ce=0; cycle 2 rom_ce=1, rom_addr=0;
  - id_valid=1 with id_inst=32'h1000_0000, id_pc=0 from cycle 3;
  - then id_pc 4, 8, 12 on consecutive cycles.
- Back-pressure: id_ready=0 for 3 cycles while id_pc=8. id_inst/id_pc hold, rom_ce=0, pc_out=12. On release, the next id_pc is 12 with no loss or duplication.
- Redirect to 32'h40 while id_valid=1, id_ready=0: next cycle id_valid=0; the following edge gives id_pc=32'h40 and id_inst=word 16.
- Misaligned redirect 32'h42: fault=1, state FAULT, rom_ce=0. A later redirect to 32'h0 clears fault and fetch resumes at word 0.
- ADDR_W=4 (16 words), RESET_PC=32'h38: fetches 0x38 and 0x3C, then fault=1 with rom_ce=0. id_valid drains after one id_ready pulse.
- halt_req together with redir_valid to 32'h20: redirect taken and fetch of 0x20 occurs. halt held one more cycle -> HALT, rom_ce=0, id_valid clears once consumed. Asserting rst mid-HALT restores all reset values.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM encoding, PC step and ROM geometry defaults.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HALT  = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_t;

    // Instructions are one 32-bit word; the PC always advances by one word.
    localparam int          PC_INC       = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_ADDR_W   = 10;
    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_PC_W     = 32;

endpackage

// File: rtl/inst_fetch_ctrl_if_id_reg.sv
// IF/ID hand-off register: a single-entry valid/ready slot with load, hold and flush.
module if_id_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] ld_inst,
    input  logic [PC_W-1:0]   ld_pc,
    output logic              valid,
    output logic [DATA_W-1:0] inst,
    output logic [PC_W-1:0]   pc
);

    logic              vld_p1;
    logic [DATA_W-1:0] inst_p1;
    logic [PC_W-1:0]   pc_p1;

    // Flush beats load; a load only arrives when the slot is empty or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            inst_p1 <= '0;
            pc_p1   <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            inst_p1 <= ld_inst;
            pc_p1   <= ld_pc;
        end else if (ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign valid = vld_p1;
    assign inst  = inst_p1;
    assign pc    = pc_p1;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM and feeds the IF/ID slot.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    input  logic              halt_req,
    output logic              fault,
    output logic [PC_W-1:0]   pc_out
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            in_range;
    logic            fetch_go;
    logic            redir_misaligned;

    // A PC is fetchable only while its word index fits inside the ROM.
    assign in_range         = ((pc_q >> (ADDR_W + 2)) == '0);
    assign redir_misaligned = (redir_pc[1:0] != 2'b00);

    // The redirect cycle never fetches, and nothing is fetched while the slot is stalled.
    assign fetch_go = (state_q == FS_FETCH) && in_range && (!id_valid || id_ready)
                      && !redir_valid && !rst;

    assign rom_ce   = fetch_go;
    assign rom_addr = pc_q[ADDR_W+1:2];
    assign pc_out   = pc_q;
    assign fault    = fault_q;

    // Next-state logic: redirect has top priority and is the only way out of HALT/FAULT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redir_valid) begin
            pc_d = redir_pc;
            if (redir_misaligned) begin
                state_d = FS_FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = FS_FETCH;
                fault_d = 1'b0;
            end
        end else begin
            case (state_q)
                FS_IDLE: begin
                    state_d = FS_FETCH;
                end
                FS_FETCH: begin
                    if (fetch_go) begin
                        pc_d = pc_q + PC_W'(PC_INC);
                    end
                    if (!in_range) begin
                        state_d = FS_FAULT;
                        fault_d = 1'b1;
                    end else if (halt_req) begin
                        state_d = FS_HALT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, PC and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (fetch_go),
        .flush   (redir_valid),
        .ready   (id_ready),
        .ld_inst (rom_data),
        .ld_pc   (pc_q),
        .valid   (id_valid),
        .inst    (id_inst),
        .pc      (id_pc)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed scenarios then randomized traffic.
module tb_inst_fetch_ctrl;

    localparam int AW        = 5;
    localparam int ROM_WORDS = 1 << AW;
    localparam int ROM_BYTES = ROM_WORDS * 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_inst;
    logic [31:0]   id_pc;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          halt_req;
    logic          fault;
    logic [31:0]   pc_out;

    logic [31:0]   rom [ROM_WORDS];

    xfer_t         exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model: fetch position and status flags.
    bit            m_init    = 1'b0;
    bit            m_started = 1'b0;
    bit            m_parked  = 1'b0;
    bit            m_fault   = 1'b0;
    bit            m_valid   = 1'b0;
    logic [31:0]   m_pc      = 32'h0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (32),
        .PC_W     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt_req    (halt_req),
        .fault       (fault),
        .pc_out      (pc_out)
    );

    initial begin
        for (int k = 0; k < ROM_WORDS; k++) rom[k] = 32'h1000_0000 + k;
    end

    // Poison value when disabled so a stray sample is visible.
    assign rom_data = rom_ce ? rom[rom_addr] : 32'hDEAD_BEEF;

    function automatic bit in_rom(input logic [31:0] a);
        return a < 32'(ROM_BYTES);
    endfunction

    function automatic bit exp_ce();
        return m_init && !rst && !redir_valid && m_started && !m_parked && !m_fault
               && in_rom(m_pc) && (!m_valid || id_ready);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model advances on every rising edge using the inputs held over that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_init    = 1'b1;
                m_started = 1'b0;
                m_parked  = 1'b0;
                m_fault   = 1'b0;
                m_valid   = 1'b0;
                m_pc      = 32'h0;
                exp_q.delete();
            end else if (m_init) begin
                if (redir_valid) begin
                    m_valid   = 1'b0;
                    exp_q.delete();
                    m_pc      = redir_pc;
                    m_started = 1'b1;
                    m_parked  = 1'b0;
                    m_fault   = (redir_pc[1:0] != 2'b00);
                end else if (!m_started) begin
                    m_started = 1'b1;
                end else begin
                    bit go;
                    bit inr;
                    go  = exp_ce();
                    inr = in_rom(m_pc);
                    if (go) begin
                        exp_q.push_back('{pc: m_pc, inst: 32'h1000_0000 + (m_pc >> 2)});
                        m_valid = 1'b1;
                        m_pc    = m_pc + 32'd4;
                    end else if (m_valid && id_ready) begin
                        m_valid = 1'b0;
                    end
                    if (!m_parked && !m_fault) begin
                        if (!inr) m_fault = 1'b1;
                        else if (halt_req) m_parked = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle and retires hand-offs accepted by decode.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                check("rom_ce", {31'b0, rom_ce}, {31'b0, exp_ce()});
                if (exp_ce()) check("rom_addr", {27'b0, rom_addr}, {27'b0, m_pc[AW+1:2]});
                check("pc_out", pc_out, m_pc);
                check("fault", {31'b0, fault}, {31'b0, m_fault});
                check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard: id_valid with no expected hand-off (t=%0t)", $time);
                    end else begin
                        check("id_pc", id_pc, exp_q[0].pc);
                        check("id_inst", id_inst, exp_q[0].inst);
                        if (id_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redir_valid = 1'b1;
        redir_pc    = target;
        cyc(1);
        redir_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        rst         = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        halt_req    = 1'b0;
        id_ready    = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(4);
        // Stall three cycles, then release.
        id_ready = 1'b0;
        cyc(3);
        id_ready = 1'b1;
        cyc(2);
        // Redirect while an instruction is held and stalled.
        id_ready = 1'b0;
        cyc(1);
        redirect(32'h40);
        id_ready = 1'b1;
        cyc(4);
        // Misaligned target faults; aligned redirect recovers.
        redirect(32'h42);
        cyc(3);
        redirect(32'h0);
        cyc(4);
        // Run off the end of the ROM.
        redirect(32'h78);
        cyc(4);
        id_ready = 1'b0;
        cyc(2);
        id_ready = 1'b1;
        cyc(3);
        // Redirect and halt together, then halt alone.
        halt_req = 1'b1;
        redirect(32'h20);
        cyc(1);
        halt_req = 1'b0;
        id_ready = 1'b0;
        cyc(3);
        id_ready = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            redir_valid = ($urandom_range(0, 11) == 0);
            t           = 32'($urandom_range(0, 34)) << 2;
            if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
            redir_pc    = t;
            halt_req    = ($urandom_range(0, 14) == 0);
            id_ready    = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        rst         = 1'b0;
        redir_valid = 1'b0;
        halt_req    = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
